note_layer_render: RTL and testbench

Parametrised successor to the six-track key layer renderer. It produces the 16-bit colour of the note layer for the current pixel across `NUM_TRACKS` lanes and adds two lane effects:

- a pressed-lane highlight;
- a per-lane hit flash that lasts a set number of frames.

The output is registered through a two-stage pipeline. It sits between the track scroll buffers and the layer compositor in the VGA path.

---
 rtl/note_render_pkg.sv | 22 ++
 rtl/lane_flash_timer.sv | 33 +++
 rtl/note_layer_render.sv | 113 +++++++++++
 tb/tb_note_layer_render.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/note_render_pkg.sv
// rtl/note_render_pkg.sv - shared constants and lane geometry helper for the note layer renderer
//   Default colours, flash counter width, and lane_center() used for lane
//   column bounds by the track-line and judgement logic.
package note_render_pkg;

  localparam int          FLASH_CNT_W       = 8;
  localparam logic [15:0] DEF_NOTE_COLOR    = 16'hfaaf;
  localparam logic [15:0] DEF_FLASH_COLOR   = 16'hffff;
  localparam logic [15:0] DEF_PRESS_COLOR   = 16'hfccf;
  localparam logic [15:0] DEF_BG_COLOR      = 16'hfff0;

  // Lane centre in 11-bit unsigned arithmetic, floor of (2*start + pitch + line_w)/2.
  function automatic logic [10:0] lane_center(input int lane, input int x_shift,
                                              input int pitch, input int line_w);
    logic [10:0] start;
    logic [10:0] twice;
    start = 11'(x_shift) + 11'(lane) * 11'(pitch);
    twice = (start << 1) + 11'(pitch) + 11'(line_w);
    return twice >> 1;
  endfunction

endpackage

// File: rtl/lane_flash_timer.sv
// rtl/lane_flash_timer.sv - per-lane hit flash frame counter
//   OriginalClk  : pixel clock
//   ResetN       : asynchronous active-low reset, clears the counter
//   load         : hit pulse, reloads FLASH_FRAMES (wins over frame_tick)
//   frame_tick   : frame start, decrements a nonzero count
//   flashing     : count is nonzero
module lane_flash_timer
  import note_render_pkg::*;
#(
  parameter int FLASH_FRAMES = 8
) (
  input  logic OriginalClk,
  input  logic ResetN,
  input  logic load,
  input  logic frame_tick,
  output logic flashing
);

  logic [FLASH_CNT_W-1:0] count;

  always_ff @(posedge OriginalClk or negedge ResetN) begin
    if (!ResetN) begin
      count <= '0;
    end else if (load) begin
      count <= FLASH_CNT_W'(FLASH_FRAMES);
    end else if (frame_tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign flashing = (count != '0);

endmodule

// File: rtl/note_layer_render.sv
// rtl/note_layer_render.sv - two-stage note layer colour renderer with press highlight and hit flash
//   OriginalClk/ResetN     : pixel clock, asynchronous active-low reset
//   XPosition/YPosition    : current pixel, PixelValid qualifies them
//   FrameStart             : one pulse per frame, ages the flash timers
//   TrackData              : lane i at [i*ROWS +: ROWS], bit y = note at row y
//   KeyPressed/HitPulse    : per-lane key level and hit pulse
//   LayerOutput/LayerValid : pixel colour two edges after X/Y, and its valid
module note_layer_render
  import note_render_pkg::*;
#(
  parameter int          NUM_TRACKS   = 6,
  parameter int          ROWS         = 480,
  parameter int          TRACK_PITCH  = 100,
  parameter int          X_SHIFT      = 20,
  parameter int          LINE_W       = 3,
  parameter int          KEY_HALF_W   = 40,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [15:0] NOTE_COLOR   = DEF_NOTE_COLOR,
  parameter logic [15:0] FLASH_COLOR  = DEF_FLASH_COLOR,
  parameter logic [15:0] PRESS_COLOR  = DEF_PRESS_COLOR,
  parameter logic [15:0] BG_COLOR     = DEF_BG_COLOR
) (
  input  logic                       OriginalClk,
  input  logic                       ResetN,
  input  logic [9:0]                 XPosition,
  input  logic [9:0]                 YPosition,
  input  logic                       PixelValid,
  input  logic                       FrameStart,
  input  logic [NUM_TRACKS*ROWS-1:0] TrackData,
  input  logic [NUM_TRACKS-1:0]      KeyPressed,
  input  logic [NUM_TRACKS-1:0]      HitPulse,
  output logic [15:0]                LayerOutput,
  output logic                       LayerValid
);

  localparam logic [10:0]     ROWS_11 = 11'(ROWS);
  localparam logic [ROWS-1:0] ROW_ONE = 1;

  logic [10:0]           x_11;
  logic                  y_in_range;
  logic [NUM_TRACKS-1:0] column;
  logic [NUM_TRACKS-1:0] note_hit;
  logic [NUM_TRACKS-1:0] press_col;
  logic [NUM_TRACKS-1:0] flashing;

  logic [NUM_TRACKS-1:0] note_hit_q;
  logic [NUM_TRACKS-1:0] flash_q;
  logic [NUM_TRACKS-1:0] press_q;
  logic                  valid_q;

  assign x_11       = {1'b0, XPosition};
  assign y_in_range = ({1'b0, YPosition} < ROWS_11);

  for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_lane
    localparam logic [10:0] CENTER = lane_center(g, X_SHIFT, TRACK_PITCH, LINE_W);
    localparam logic [10:0] LO     = CENTER - 11'(KEY_HALF_W);
    localparam logic [10:0] HI     = CENTER + 11'(KEY_HALF_W);

    logic [ROWS-1:0] lane_bits;
    assign lane_bits = TrackData[g*ROWS +: ROWS];

    // Shifting a one-hot mask keeps every data bit in use and yields 0 for Y >= ROWS.
    assign column[g]    = (x_11 > LO) && (x_11 < HI);
    assign note_hit[g]  = column[g] && y_in_range && (|(lane_bits & (ROW_ONE << YPosition)));
    assign press_col[g] = column[g] && KeyPressed[g];

    lane_flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES)
    ) u_flash_timer (
      .OriginalClk (OriginalClk),
      .ResetN      (ResetN),
      .load        (HitPulse[g]),
      .frame_tick  (FrameStart),
      .flashing    (flashing[g])
    );
  end

  // Stage 1: per-lane vectors; flashing is the counter state before this edge's update.
  always_ff @(posedge OriginalClk or negedge ResetN) begin
    if (!ResetN) begin
      note_hit_q <= '0;
      flash_q    <= '0;
      press_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      note_hit_q <= note_hit;
      flash_q    <= flashing;
      press_q    <= press_col;
      valid_q    <= PixelValid;
    end
  end

  // Stage 2: colour priority. Every lane of a class maps to the same colour,
  // so OR-reduction already honours the lowest-lane-wins rule.
  always_ff @(posedge OriginalClk or negedge ResetN) begin
    if (!ResetN) begin
      LayerOutput <= BG_COLOR;
      LayerValid  <= 1'b0;
    end else begin
      LayerValid <= valid_q;
      if (|(note_hit_q & flash_q)) begin
        LayerOutput <= FLASH_COLOR;
      end else if (|note_hit_q) begin
        LayerOutput <= NOTE_COLOR;
      end else if (|press_q) begin
        LayerOutput <= PRESS_COLOR;
      end else begin
        LayerOutput <= BG_COLOR;
      end
    end
  end

endmodule

// File: tb/tb_note_layer_render.sv
// tb/tb_note_layer_render.sv - directed self-checking bench for note_layer_render
module tb_note_layer_render;

  localparam int ROWS = 480;

  logic                OriginalClk = 1'b0;
  logic                ResetN;
  logic [9:0]          XPosition;
  logic [9:0]          YPosition;
  logic                PixelValid;
  logic                FrameStart;
  logic [6*ROWS-1:0]   TrackData;
  logic [5:0]          KeyPressed;
  logic [5:0]          HitPulse;
  logic [15:0]         LayerOutput;
  logic                LayerValid;

  logic [4*ROWS-1:0]   TrackData4;
  logic [3:0]          KeyPressed4;
  logic [3:0]          HitPulse4;
  logic [15:0]         LayerOutput4;
  logic                LayerValid4;

  int n_vec = 0;
  int n_err = 0;

  always #5 OriginalClk = ~OriginalClk;

  note_layer_render u_dut (
    .OriginalClk (OriginalClk),
    .ResetN      (ResetN),
    .XPosition   (XPosition),
    .YPosition   (YPosition),
    .PixelValid  (PixelValid),
    .FrameStart  (FrameStart),
    .TrackData   (TrackData),
    .KeyPressed  (KeyPressed),
    .HitPulse    (HitPulse),
    .LayerOutput (LayerOutput),
    .LayerValid  (LayerValid)
  );

  note_layer_render #(
    .NUM_TRACKS  (4),
    .TRACK_PITCH (150)
  ) u_dut4 (
    .OriginalClk (OriginalClk),
    .ResetN      (ResetN),
    .XPosition   (XPosition),
    .YPosition   (YPosition),
    .PixelValid  (PixelValid),
    .FrameStart  (FrameStart),
    .TrackData   (TrackData4),
    .KeyPressed  (KeyPressed4),
    .HitPulse    (HitPulse4),
    .LayerOutput (LayerOutput4),
    .LayerValid  (LayerValid4)
  );

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge OriginalClk);
    #1;
  endtask

  // Present a pixel and check the main instance's colour two edges later.
  task automatic pix(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input logic [15:0] exp);
    XPosition  = x;
    YPosition  = y;
    PixelValid = 1'b1;
    tick();
    tick();
    check_vec(tag, LayerOutput, exp);
  endtask

  task automatic pix4(input string tag, input logic [9:0] x, input logic [9:0] y,
                      input logic [15:0] exp);
    XPosition  = x;
    YPosition  = y;
    PixelValid = 1'b1;
    tick();
    tick();
    check_vec(tag, LayerOutput4, exp);
  endtask

  task automatic hit_lane(input int lane, input logic with_frame);
    HitPulse[lane] = 1'b1;
    FrameStart     = with_frame;
    tick();
    HitPulse   = '0;
    FrameStart = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      FrameStart = 1'b1;
      tick();
      FrameStart = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs.
    ResetN      = 1'b0;
    XPosition   = 10'($urandom);
    YPosition   = 10'($urandom);
    PixelValid  = 1'b1;
    FrameStart  = 1'($urandom);
    KeyPressed  = 6'($urandom);
    HitPulse    = 6'($urandom);
    KeyPressed4 = '0;
    HitPulse4   = '0;
    TrackData4  = '0;
    for (int i = 0; i < 6*ROWS/32 + 1; i++) begin
      if (i*32 < 6*ROWS) TrackData[i*32 +: 32] = $urandom;
    end
    repeat (3) tick();
    check_vec("reset_out", LayerOutput, 16'hfff0);
    check_vec("reset_valid", {15'd0, LayerValid}, 16'h0000);

    // Release and first valid pixel.
    TrackData  = '0;
    TrackData[10] = 1'b1;
    KeyPressed = '0;
    HitPulse   = '0;
    FrameStart = 1'b0;
    XPosition  = 10'd71;
    YPosition  = 10'd10;
    PixelValid = 1'b1;
    ResetN     = 1'b1;
    tick();
    check_vec("first_edge_valid", {15'd0, LayerValid}, 16'h0000);
    tick();
    check_vec("second_edge_out", LayerOutput, 16'hfaaf);
    check_vec("second_edge_valid", {15'd0, LayerValid}, 16'h0001);

    // Lane 0 strict bounds (32..110).
    pix("l0_x31", 10'd31, 10'd10, 16'hfff0);
    pix("l0_x32", 10'd32, 10'd10, 16'hfaaf);
    pix("l0_x110", 10'd110, 10'd10, 16'hfaaf);
    pix("l0_x111", 10'd111, 10'd10, 16'hfff0);

    // Lane 1 bounds (132..210).
    TrackData = '0;
    TrackData[1*ROWS + 20] = 1'b1;
    pix("l1_x131", 10'd131, 10'd20, 16'hfff0);
    pix("l1_x132", 10'd132, 10'd20, 16'hfaaf);
    pix("l1_x210", 10'd210, 10'd20, 16'hfaaf);
    pix("l1_x211", 10'd211, 10'd20, 16'hfff0);
    pix("l1_wrong_row", 10'd171, 10'd21, 16'hfff0);

    // Pressed lane highlight, then note above press.
    TrackData  = '0;
    KeyPressed = 6'b000100;
    pix("press_l2", 10'd271, 10'd30, 16'hfccf);
    pix("press_other_lane", 10'd171, 10'd30, 16'hfff0);
    TrackData[2*ROWS + 30] = 1'b1;
    pix("press_with_note", 10'd271, 10'd30, 16'hfaaf);
    KeyPressed = '0;

    // Invalid pixel propagates to LayerValid.
    XPosition  = 10'd271;
    PixelValid = 1'b0;
    tick();
    tick();
    check_vec("invalid_valid", {15'd0, LayerValid}, 16'h0000);

    // Hit flash on lane 3 (center 371), note at row 50.
    TrackData = '0;
    TrackData[3*ROWS + 50] = 1'b1;
    pix("flash_idle", 10'd371, 10'd50, 16'hfaaf);
    hit_lane(3, 1'b0);
    pix("flash_after_hit", 10'd371, 10'd50, 16'hffff);
    for (int k = 1; k <= 8; k++) begin
      frames(1);
      pix($sformatf("flash_frame%0d", k), 10'd371, 10'd50, (k < 8) ? 16'hffff : 16'hfaaf);
    end

    // Load wins over a coincident decrement at count 1.
    hit_lane(3, 1'b0);
    frames(7);
    pix("flash_count1", 10'd371, 10'd50, 16'hffff);
    hit_lane(3, 1'b1);
    pix("coincide_reload", 10'd371, 10'd50, 16'hffff);
    frames(7);
    pix("coincide_7frames", 10'd371, 10'd50, 16'hffff);
    frames(1);
    pix("coincide_8frames", 10'd371, 10'd50, 16'hfaaf);

    // Flash without a note in that pixel shows only the base layer.
    hit_lane(3, 1'b0);
    pix("flash_no_note", 10'd371, 10'd51, 16'hfff0);

    // Y range.
    TrackData = '1;
    pix("y480", 10'd71, 10'd480, 16'hfff0);
    pix("y479", 10'd71, 10'd479, 16'hfaaf);
    pix("y1023", 10'd71, 10'd1023, 16'hfff0);

    // Parametrised instance: lane 3 center 546, window 507..585.
    TrackData4 = '0;
    TrackData4[3*ROWS + 40] = 1'b1;
    pix4("p4_x506", 10'd506, 10'd40, 16'hfff0);
    pix4("p4_x507", 10'd507, 10'd40, 16'hfaaf);
    pix4("p4_x585", 10'd585, 10'd40, 16'hfaaf);
    pix4("p4_x586", 10'd586, 10'd40, 16'hfff0);

    // Mid-frame async reset clears outputs and flash counters.
    TrackData = '0;
    TrackData[3*ROWS + 50] = 1'b1;
    hit_lane(3, 1'b0);
    pix("pre_reset_flash", 10'd371, 10'd50, 16'hffff);
    ResetN = 1'b0;
    #1;
    check_vec("async_reset_out", LayerOutput, 16'hfff0);
    check_vec("async_reset_valid", {15'd0, LayerValid}, 16'h0000);
    tick();
    ResetN = 1'b1;
    pix("post_reset_no_flash", 10'd371, 10'd50, 16'hfaaf);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
